// File: rtl/pic_bus_pkg.sv
// Shared encodings for the 8259A host bus master: engine states, init steps,
// ICW1 bit positions and A0 register-select values.
package pic_bus_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} bus_state_e;

  typedef enum logic [1:0] {ICW1, ICW2, ICW3, ICW4} init_step_e;

  localparam int IC4  = 0;
  localparam int SNGL = 1;

  localparam logic A0_ICW1_OCW23 = 1'b0;
  localparam logic A0_ICW24_OCW1 = 1'b1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pic_bus_cycle.sv
// Single 8259A bus-cycle engine: SETUP -> STROBE -> HOLD with registered strobes,
// write-data drive and read capture at the end of the strobe.
module pic_bus_cycle
  import pic_bus_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       write,
  input  logic       a0,
  input  logic [7:0] wdata,
  input  logic [7:0] data_bus_in,
  output logic       idle,
  output logic       last,
  output logic       CS_bar,
  output logic       WR_bar,
  output logic       RD_bar,
  output logic       A0,
  output logic [7:0] data_bus_out,
  output logic       data_bus_oe,
  output logic       rsp_valid,
  output logic [7:0] rsp_data
);

  localparam int CNT_W = $clog2(max3(SETUP_CYC, STROBE_CYC, HOLD_CYC) + 1);
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

  bus_state_e       state;
  logic [CNT_W-1:0] cnt;
  logic             wr_q;

  assign idle = (state == IDLE);
  assign last = (state == HOLD) && (cnt == '0);

  // cnt counts down the remaining cycles of the current phase; it is reloaded on every phase entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      wr_q         <= 1'b0;
      CS_bar       <= 1'b1;
      WR_bar       <= 1'b1;
      RD_bar       <= 1'b1;
      A0           <= 1'b0;
      data_bus_out <= '0;
      data_bus_oe  <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state        <= SETUP;
            cnt          <= SETUP_LD;
            wr_q         <= write;
            CS_bar       <= 1'b0;
            A0           <= a0;
            data_bus_out <= wdata;
            data_bus_oe  <= write;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            state  <= STROBE;
            cnt    <= STROBE_LD;
            WR_bar <= ~wr_q;
            RD_bar <= wr_q;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        STROBE: begin
          if (cnt == '0) begin
            state  <= HOLD;
            cnt    <= HOLD_LD;
            WR_bar <= 1'b1;
            RD_bar <= 1'b1;
            if (!wr_q) begin
              rsp_valid <= 1'b1;
              rsp_data  <= data_bus_in;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            state       <= IDLE;
            CS_bar      <= 1'b1;
            data_bus_oe <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/pic_bus_master.sv
// 8259A host bus master: command arbiter plus optional ICW1..ICW4 init sequencer.
// The sequencer is built only when PIC_BUS_MASTER_INIT_EN is defined.
module pic_bus_master
  import pic_bus_pkg::*;
#(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_write,
  input  logic       cmd_a0,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  input  logic       init_start,
  input  logic [7:0] icw1,
  input  logic [7:0] icw2,
  input  logic [7:0] icw3,
  input  logic [7:0] icw4,
  output logic       init_busy,
  output logic       init_done,
  output logic       CS_bar,
  output logic       WR_bar,
  output logic       RD_bar,
  output logic       A0,
  output logic [7:0] data_bus_out,
  output logic       data_bus_oe,
  input  logic [7:0] data_bus_in
);

  logic       eng_idle;
  logic       eng_last;
  logic       eng_start;
  logic       eng_write;
  logic       eng_a0;
  logic [7:0] eng_data;

`ifdef PIC_BUS_MASTER_INIT_EN
  init_step_e step;
  init_step_e step_nxt;
  logic       step_fin;
  logic [7:0] icw1_q, icw2_q, icw3_q, icw4_q;
  logic       init_go;

  // init_start wins over a simultaneous command, so ready drops while it is asserted
  assign init_go   = init_start && eng_idle && !init_busy;
  assign cmd_ready = eng_idle && !init_busy && !init_start;

  always_comb begin
    step_nxt = step;
    step_fin = 1'b0;
    case (step)
      ICW1: step_nxt = ICW2;
      ICW2: begin
        if (!icw1_q[SNGL])     step_nxt = ICW3;
        else if (icw1_q[IC4])  step_nxt = ICW4;
        else                   step_fin = 1'b1;
      end
      ICW3: begin
        if (icw1_q[IC4]) step_nxt = ICW4;
        else             step_fin = 1'b1;
      end
      default: step_fin = 1'b1;
    endcase
  end

  always_comb begin
    eng_start = cmd_valid && cmd_ready;
    eng_write = cmd_write;
    eng_a0    = cmd_a0;
    eng_data  = cmd_data;
    if (init_busy) begin
      eng_start = eng_idle;
      eng_write = 1'b1;
      eng_a0    = A0_ICW24_OCW1;
      case (step)
        ICW1: begin
          eng_a0   = A0_ICW1_OCW23;
          eng_data = icw1_q;
        end
        ICW2:    eng_data = icw2_q;
        ICW3:    eng_data = icw3_q;
        default: eng_data = icw4_q;
      endcase
    end
  end

  // The engine's return to IDLE provides the one-cycle CS_bar-high gap between ICWs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      init_busy <= 1'b0;
      init_done <= 1'b0;
      step      <= ICW1;
      icw1_q    <= '0;
      icw2_q    <= '0;
      icw3_q    <= '0;
      icw4_q    <= '0;
    end else begin
      init_done <= 1'b0;
      if (init_go) begin
        init_busy <= 1'b1;
        step      <= ICW1;
        icw1_q    <= icw1;
        icw2_q    <= icw2;
        icw3_q    <= icw3;
        icw4_q    <= icw4;
      end else if (init_busy && eng_last) begin
        if (step_fin) begin
          init_busy <= 1'b0;
          init_done <= 1'b1;
        end else begin
          step <= step_nxt;
        end
      end
    end
  end
`else
  logic unused_init;
  assign unused_init = ^{init_start, icw1, icw2, icw3, icw4, eng_last};

  assign cmd_ready = eng_idle;
  assign eng_start = cmd_valid && eng_idle;
  assign eng_write = cmd_write;
  assign eng_a0    = cmd_a0;
  assign eng_data  = cmd_data;
  assign init_busy = 1'b0;
  assign init_done = 1'b0;
`endif

  pic_bus_cycle #(
    .SETUP_CYC (SETUP_CYC),
    .STROBE_CYC(STROBE_CYC),
    .HOLD_CYC  (HOLD_CYC)
  ) u_cycle (
    .clk         (clk),
    .reset       (reset),
    .start       (eng_start),
    .write       (eng_write),
    .a0          (eng_a0),
    .wdata       (eng_data),
    .data_bus_in (data_bus_in),
    .idle        (eng_idle),
    .last        (eng_last),
    .CS_bar      (CS_bar),
    .WR_bar      (WR_bar),
    .RD_bar      (RD_bar),
    .A0          (A0),
    .data_bus_out(data_bus_out),
    .data_bus_oe (data_bus_oe),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data)
  );

endmodule

// File: tb/tb_pic_bus_master.sv
// Bench for pic_bus_master: random single cycles against a phase-timeline model,
// ICW sequences against an expected write list, async reset, and a 2/3/2 timing instance.
module tb_pic_bus_master;

  localparam int S  = 1, T  = 2, H  = 1;
  localparam int S2 = 2, T2 = 3, H2 = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic       cmd_valid = 1'b0, cmd_write = 1'b0, cmd_a0 = 1'b0;
  logic [7:0] cmd_data = '0;
  logic       cmd_ready, rsp_valid, init_busy, init_done;
  logic [7:0] rsp_data;
  logic       init_start = 1'b0;
  logic [7:0] icw1 = '0, icw2 = '0, icw3 = '0, icw4 = '0;
  logic       cs_b, wr_b, rd_b, a0, oe;
  logic [7:0] dout, din, rd_val = '0;

  // the 8259 model only drives read data while RD_bar is low
  assign din = rd_b ? 8'h00 : rd_val;

  logic       cmd_valid2 = 1'b0, cmd_write2 = 1'b0, cmd_a02 = 1'b0;
  logic [7:0] cmd_data2 = '0;
  logic       cmd_ready2, rsp_valid2, init_busy2, init_done2;
  logic [7:0] rsp_data2;
  logic       init_start2 = 1'b0;
  logic [7:0] icw_zero = '0;
  logic       cs_b2, wr_b2, rd_b2, a02, oe2;
  logic [7:0] dout2;
  logic [7:0] din2 = 8'h3C;

  pic_bus_master dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_a0(cmd_a0), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .init_start(init_start),
    .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4),
    .init_busy(init_busy), .init_done(init_done),
    .CS_bar(cs_b), .WR_bar(wr_b), .RD_bar(rd_b), .A0(a0),
    .data_bus_out(dout), .data_bus_oe(oe), .data_bus_in(din)
  );

  pic_bus_master #(.SETUP_CYC(S2), .STROBE_CYC(T2), .HOLD_CYC(H2)) dut2 (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
    .cmd_write(cmd_write2), .cmd_a0(cmd_a02), .cmd_data(cmd_data2),
    .rsp_valid(rsp_valid2), .rsp_data(rsp_data2), .init_start(init_start2),
    .icw1(icw_zero), .icw2(icw_zero), .icw3(icw_zero), .icw4(icw_zero),
    .init_busy(init_busy2), .init_done(init_done2),
    .CS_bar(cs_b2), .WR_bar(wr_b2), .RD_bar(rd_b2), .A0(a02),
    .data_bus_out(dout2), .data_bus_oe(oe2), .data_bus_in(din2)
  );

  int n_chk = 0;
  int n_pass = 0;
  logic [7:0] last_rd = '0;

  logic [8:0] wins[$];
  int         gaps[$];
  int         done_cnt, rdy_busy, busy_cnt;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One command through the handshake; caller is at a negedge. Checks every cycle
  // of the SETUP/STROBE/HOLD timeline; optionally pokes cmd_valid while busy.
  task automatic bus_cmd(input logic w, input logic a, input logic [7:0] d,
                         input logic [7:0] rv, input bit poke);
    int  waited;
    int  L;
    bit  strobe;
    L = S + T + H;
    cmd_write = w; cmd_a0 = a; cmd_data = d; rd_val = rv; cmd_valid = 1'b1;
    waited = 0;
    while (!cmd_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_ready) begin
      check_eq("accept_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int k = 1; k <= L + 1; k++) begin
      @(negedge clk);
      strobe = (k > S) && (k <= S + T);
      if (!w && k == S + T + 1) last_rd = rv;
      check_eq("bus_strobes", 32'({cs_b, wr_b, rd_b, oe}),
               32'({k > L, !(strobe && w), !(strobe && !w), w && (k <= L)}));
      if (k <= L) check_eq("a0", 32'(a0), 32'(a));
      if (w && k <= L) check_eq("wdata", 32'(dout), 32'(d));
      check_eq("rsp_valid", 32'(rsp_valid), 32'(!w && k == S + T + 1));
      check_eq("rsp_data", 32'(rsp_data), 32'(last_rd));
      check_eq("cmd_ready", 32'(cmd_ready), 32'(k == L + 1));
      if (poke && k == 2) begin
        cmd_valid = 1'b1;
        cmd_data  = ~d;
      end
      if (poke && k == 3) cmd_valid = 1'b0;
    end
    if (poke) begin
      repeat (2) begin
        @(negedge clk);
        check_eq("stray_cmd_cs", 32'(cs_b), 32'd1);
      end
    end
  endtask

  // Observe CS_bar-low windows until n are complete; drops cmd_valid once accepted.
  task automatic collect(input int n, input int budget);
    int   hi;
    logic prev_cs;
    int   c;
    hi = 0; prev_cs = 1'b1; c = 0;
    wins.delete(); gaps.delete();
    done_cnt = 0; rdy_busy = 0; busy_cnt = 0;
    while (c < budget) begin
      @(negedge clk);
      c++;
      if (init_done) done_cnt++;
      if (init_busy) busy_cnt++;
      if (init_busy && cmd_ready) rdy_busy++;
      if (!cs_b && prev_cs) begin
        wins.push_back({a0, dout});
        gaps.push_back(hi);
      end
      hi = cs_b ? hi + 1 : 0;
      prev_cs = cs_b;
      if (wins.size() >= n && cs_b) break;
      if (cmd_valid && cmd_ready) begin
        @(posedge clk);
        #1 cmd_valid = 1'b0;
      end
    end
    if (c >= budget) check_eq("collect_timeout", 32'(wins.size()), 32'(n));
  endtask

  // Init request raised together with a held write command (cd, A0=1).
  task automatic init_run(input logic [7:0] i1, input logic [7:0] i2,
                          input logic [7:0] i3, input logic [7:0] i4, input logic [7:0] cd);
    logic [8:0] expq[$];
    logic       took;
    expq.push_back({1'b0, i1});
    expq.push_back({1'b1, i2});
    if (!i1[1]) expq.push_back({1'b1, i3});
    if (i1[0])  expq.push_back({1'b1, i4});
    icw1 = i1; icw2 = i2; icw3 = i3; icw4 = i4;
    init_start = 1'b1;
    cmd_write = 1'b1; cmd_a0 = 1'b1; cmd_data = cd; cmd_valid = 1'b1;
    #1;
    took = cmd_ready;
`ifdef PIC_BUS_MASTER_INIT_EN
    check_eq("init_prio_ready", 32'(took), 32'd0);
`else
    check_eq("noinit_ready", 32'(took), 32'd1);
`endif
    @(posedge clk);
    #1;
    init_start = 1'b0;
    icw1 = 8'($urandom); icw2 = 8'($urandom); icw3 = 8'($urandom); icw4 = 8'($urandom);
    if (took) cmd_valid = 1'b0;
`ifdef PIC_BUS_MASTER_INIT_EN
    collect(expq.size() + 1, 100);
    check_eq("icw_count", 32'(wins.size()), 32'(expq.size() + 1));
    for (int i = 0; i < expq.size() && i < wins.size(); i++) begin
      check_eq($sformatf("icw%0d", i), 32'(wins[i]), 32'(expq[i]));
      if (i > 0) check_eq($sformatf("icw_gap%0d", i), 32'(gaps[i]), 32'd1);
    end
    if (wins.size() > expq.size())
      check_eq("held_cmd", 32'(wins[expq.size()]), 32'({1'b1, cd}));
    check_eq("init_done_pulses", 32'(done_cnt), 32'd1);
    check_eq("ready_while_busy", 32'(rdy_busy), 32'd0);
    check_eq("busy_after", 32'(init_busy), 32'd0);
`else
    collect(1, 30);
    check_eq("noinit_windows", 32'(wins.size()), 32'd1);
    if (wins.size() > 0) check_eq("noinit_cmd", 32'(wins[0]), 32'({1'b1, cd}));
    check_eq("noinit_busy", 32'(busy_cnt), 32'd0);
    check_eq("noinit_done", 32'(done_cnt), 32'd0);
`endif
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] r1;
    @(negedge clk);
    check_eq("rst_bus", 32'({cs_b, wr_b, rd_b, a0, oe}), 32'(5'b11100));
    check_eq("rst_dout", 32'(dout), 32'd0);
    check_eq("rst_rsp", 32'({rsp_valid, rsp_data}), 32'd0);
    check_eq("rst_init", 32'({init_busy, init_done}), 32'd0);
    check_eq("rst_bus2", 32'({cs_b2, wr_b2, rd_b2, oe2}), 32'(4'b1110));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("ready_after_rst", 32'(cmd_ready), 32'd1);

    bus_cmd(1'b1, 1'b1, 8'hAA, 8'h00, 1'b0);
    bus_cmd(1'b0, 1'b0, 8'h00, 8'h5C, 1'b0);
    bus_cmd(1'b1, 1'b0, 8'h33, 8'h00, 1'b1);

    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      bus_cmd(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), (i % 6) == 5);
    end

    init_run(8'h11, 8'h20, 8'h04, 8'h01, 8'hC1);
    init_run(8'h13, 8'h28, 8'h55, 8'h03, 8'hC2);
    init_run(8'h12, 8'h30, 8'h66, 8'h77, 8'hC3);
    for (int i = 0; i < 2; i++) begin
      r1 = 8'($urandom);
      init_run(r1, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
    end

    // async reset during the strobe of a write
    cmd_write = 1'b1; cmd_a0 = 1'b1; cmd_data = 8'h96; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("pre_rst_wr", 32'({cs_b, wr_b, oe}), 32'(3'b001));
    #2 reset = 1'b0;
    #1;
    check_eq("async_rst_bus", 32'({cs_b, wr_b, rd_b, oe}), 32'(4'b1110));
    @(negedge clk);
    reset = 1'b1;
    last_rd = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq("post_rst_ready", 32'(cmd_ready), 32'd1);
      check_eq("post_rst_rsp", 32'({rsp_valid, cs_b}), 32'(2'b01));
    end
    bus_cmd(1'b0, 1'b1, 8'h00, 8'hE7, 1'b0);

    // stretched timing instance
    cmd_write2 = 1'b1; cmd_a02 = 1'b0; cmd_data2 = 8'h3E; cmd_valid2 = 1'b1;
    check_eq("t2_ready0", 32'(cmd_ready2), 32'd1);
    @(posedge clk);
    #1 cmd_valid2 = 1'b0;
    for (int k = 1; k <= S2 + T2 + H2 + 1; k++) begin
      @(negedge clk);
      check_eq("t2_bus", 32'({cs_b2, wr_b2, rd_b2, oe2}),
               32'({k > S2 + T2 + H2, !(k > S2 && k <= S2 + T2), 1'b1, k <= S2 + T2 + H2}));
      check_eq("t2_ready", 32'(cmd_ready2), 32'(k == S2 + T2 + H2 + 1));
      if (k <= S2 + T2 + H2) check_eq("t2_dout", 32'(dout2), 32'h3E);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
